// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised dual-port RAM: clear-FSM states and
// read-during-write collision mode encodings.
package ram_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port; the
// same-address read-during-write result is chosen by RD_MODE.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 2,
    parameter int RD_MODE = RD_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              fwd;

    // Write-first forwards the incoming word; read-first sees the pre-edge contents.
    assign fwd = (RD_MODE == WR_FIRST) && we && (waddr == raddr);

    // The array itself is never reset; the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= fwd ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/ram_rw_param.sv
// Simple-dual-port RAM with registered read, read-valid/drop status and a clear
// sweep that zeroes every word after reset or on request.
module ram_rw_param
    import ram_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 2,
    parameter int RD_MODE = RD_FIRST,
    parameter int CLR_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              drop
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST      = (ADDR_W + 1)'(DEPTH - 1);
    localparam state_t          RST_STATE = (CLR_RST != 0) ? ST_CLEAR : ST_RUN;

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic              sweep;
    logic              user_ok;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A clear request in the same cycle pre-empts any user access.
    always_comb begin
        sweep     = (state == ST_CLEAR);
        user_ok   = (state == ST_RUN) && !clr;
        mem_we    = sweep || (user_ok && we);
        mem_re    = user_ok && re;
        mem_waddr = sweep ? cnt[ADDR_W-1:0] : waddr;
        mem_wdata = sweep ? '0 : data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            cnt      <= '0;
            busy     <= (CLR_RST != 0);
            rd_valid <= 1'b0;
            drop     <= 1'b0;
        end else begin
            rd_valid <= mem_re;
            drop     <= (we || re) && !user_ok;
            if (clr) begin
                state <= ST_CLEAR;
                busy  <= 1'b1;
                cnt   <= '0;
            end else if (sweep) begin
                if (cnt == LAST) begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_MODE(RD_MODE)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .re   (mem_re),
        .raddr(raddr),
        .rdata(data_out)
    );

endmodule
